// File: rtl/trip_timer_bcd_if.sv
// Bundle between the drive-state decoder and the trip timer: drive state and
// hold in, ready BCD digits plus tick/running/overflow status out.
interface trip_timer_bcd_if;
    logic [3:0] state;
    logic       hold;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       tick;
    logic       running;
    logic       ovf;

    modport master (
        output state, hold,
        input  d0, d1, d2, d3, tick, running, ovf
    );

    modport slave (
        input  state, hold,
        output d0, d1, d2, d3, tick, running, ovf
    );
endinterface

// File: rtl/trip_timer_bcd.sv
// Elapsed-drive timer: counts 0.1 s ticks into four BCD digits (000.0..999.9).
// Define TRIP_TIMER_SATURATE_EN to stop at 999.9 instead of wrapping to 000.0.
module trip_timer_bcd #(
    parameter int TICK_DIV = 10000000,
    parameter int CNT_W    = 24
) (
    input logic            clk,
    input logic            rst,
    trip_timer_bcd_if.slave bus
);
    typedef enum logic [3:0] {
        ST_OFF        = 4'b0000,
        ST_NO_ST      = 4'b0011,
        ST_START      = 4'b0111,
        ST_MOVEF      = 4'b0110,
        ST_MOVEB      = 4'b0101,
        ST_KEEP_GO    = 4'b1110,
        ST_SEMI_MOVEF = 4'b1111
    } drive_state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic             is_off;
    logic             is_counting;
    logic             tick_now;
    logic             at_max;
    logic             carry;
    logic [CNT_W-1:0] prescale;
    logic [3:0][3:0]  digits;
    logic [3:0][3:0]  digits_inc;
    logic [3:0][3:0]  digits_next;
    logic [3:0][3:0]  shown;
    logic             hold_q;
    logic             tick_q;
    logic             running_q;
    logic             ovf_q;

    always_comb begin
        is_off = (bus.state == ST_OFF);
        case (bus.state)
            ST_MOVEF, ST_MOVEB, ST_KEEP_GO, ST_SEMI_MOVEF: is_counting = 1'b1;
            default:                                       is_counting = 1'b0;
        endcase
        tick_now = is_counting && (prescale == TICK_LAST);
    end

    // Ripple the +1 through the digits; a digit at 9 rolls to 0 and passes the carry up.
    always_comb begin
        digits_inc = digits;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digits[i] == 4'd9) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        at_max = (digits == 16'h9999);
`ifdef TRIP_TIMER_SATURATE_EN
        digits_next = at_max ? digits : digits_inc;
`else
        digits_next = digits_inc;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale  <= '0;
            digits    <= '0;
            shown     <= '0;
            hold_q    <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tick_q    <= tick_now;
            running_q <= is_counting;
            hold_q    <= bus.hold;

            // Non-counting, non-off states leave the partial prescale intact so a resume continues mid-tick.
            if (is_off) begin
                prescale <= '0;
                digits   <= '0;
                ovf_q    <= 1'b0;
            end else if (is_counting) begin
                if (tick_now) begin
                    prescale <= '0;
                    digits   <= digits_next;
                    if (at_max) begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    prescale <= prescale + CNT_W'(1);
                end
            end

            // Freeze only once hold has been seen high on two consecutive edges, so the first high edge captures.
            if (is_off) begin
                shown <= '0;
            end else if (!(bus.hold && hold_q)) begin
                shown <= digits;
            end
        end
    end

    assign bus.d0      = shown[0];
    assign bus.d1      = shown[1];
    assign bus.d2      = shown[2];
    assign bus.d3      = shown[3];
    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_trip_timer_bcd.sv
// Bench for trip_timer_bcd: integer-valued elapsed-time model compared every cycle,
// directed milestones with literal expectations, then randomized drive states.
module tb_trip_timer_bcd;
    localparam int TD = 4;
    localparam int CW = 4;

    localparam logic [3:0] OFF        = 4'b0000;
    localparam logic [3:0] NO_ST      = 4'b0011;
    localparam logic [3:0] START      = 4'b0111;
    localparam logic [3:0] MOVEF      = 4'b0110;
    localparam logic [3:0] MOVEB      = 4'b0101;
    localparam logic [3:0] KEEP_GO    = 4'b1110;
    localparam logic [3:0] SEMI_MOVEF = 4'b1111;

`ifdef TRIP_TIMER_SATURATE_EN
    localparam logic [15:0] AFTER_WRAP  = 16'h9999;
    localparam logic [15:0] AFTER_WRAP2 = 16'h9999;
`else
    localparam logic [15:0] AFTER_WRAP  = 16'h0000;
    localparam logic [15:0] AFTER_WRAP2 = 16'h0002;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    logic [3:0] run_codes [4] = '{MOVEF, MOVEB, KEEP_GO, SEMI_MOVEF};

    trip_timer_bcd_if tif ();

    trip_timer_bcd #(.TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    always #5 clk = ~clk;

    // Elapsed time kept as a plain count of tenths (0..9999).
    int m_cnt  = 0;
    int m_pre  = 0;
    int m_out  = 0;
    bit m_tick = 1'b0;
    bit m_run  = 1'b0;
    bit m_ovf  = 1'b0;
    bit m_hold_prev = 1'b0;
    bit m_counting;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_out = 0;
            m_tick = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_hold_prev = 1'b0;
        end else begin
            m_counting = (tif.state inside {MOVEF, MOVEB, KEEP_GO, SEMI_MOVEF});
            if (tif.state == OFF)
                m_out = 0;
            else if (!(tif.hold && m_hold_prev))
                m_out = m_cnt;
            m_tick = m_counting && (m_pre == TD - 1);
            m_run  = m_counting;
            m_hold_prev = tif.hold;
            if (tif.state == OFF) begin
                m_pre = 0; m_cnt = 0; m_ovf = 1'b0;
            end else if (m_counting) begin
                m_pre = (m_pre + 1) % TD;
                if (m_pre == 0) begin
                    if (m_cnt == 9999) m_ovf = 1'b1;
`ifdef TRIP_TIMER_SATURATE_EN
                    m_cnt = (m_cnt == 9999) ? 9999 : m_cnt + 1;
`else
                    m_cnt = (m_cnt + 1) % 10000;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] act;
        act = {tif.d3, tif.d2, tif.d1, tif.d0};
        compared++;
        if (act !== to_bcd(m_out) || tif.tick !== m_tick || tif.running !== m_run || tif.ovf !== m_ovf) begin
            mismatched++;
            $display("[TB] FAIL cycle t=%0t: got d=%h tick=%b running=%b ovf=%b, want d=%h tick=%b running=%b ovf=%b",
                     $time, act, tif.tick, tif.running, tif.ovf, to_bcd(m_out), m_tick, m_run, m_ovf);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic h);
        tif.state = s;
        tif.hold  = h;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] ed, input logic et,
                               input logic er, input logic eo);
        logic [15:0] act;
        act = {tif.d3, tif.d2, tif.d1, tif.d0};
        compared++;
        if (act !== ed || tif.tick !== et || tif.running !== er || tif.ovf !== eo) begin
            mismatched++;
            $display("[TB] FAIL %s: got d=%h tick=%b running=%b ovf=%b, want d=%h tick=%b running=%b ovf=%b",
                     name, act, tif.tick, tif.running, tif.ovf, ed, et, er, eo);
        end
    endtask

    initial begin
        applyStimulus(OFF, 1'b0);
        rst = 1'b1;
        step(2);
        checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);

        applyStimulus(MOVEF, 1'b0);
        step(1);    checkOutput("running_entry", 16'h0000, 1'b0, 1'b1, 1'b0);
        step(3);    checkOutput("first_tick",    16'h0000, 1'b1, 1'b1, 1'b0);
        step(1);    checkOutput("first_digit",   16'h0001, 1'b0, 1'b1, 1'b0);
        step(35);   checkOutput("tick_40",       16'h0009, 1'b1, 1'b1, 1'b0);
        step(1);    checkOutput("carry_d1",      16'h0010, 1'b0, 1'b1, 1'b0);
        step(359);  checkOutput("pre_carry_d2",  16'h0099, 1'b1, 1'b1, 1'b0);
        step(1);    checkOutput("carry_d2",      16'h0100, 1'b0, 1'b1, 1'b0);
        step(3599); checkOutput("pre_carry_d3",  16'h0999, 1'b1, 1'b1, 1'b0);
        step(1);    checkOutput("carry_d3",      16'h1000, 1'b0, 1'b1, 1'b0);

        applyStimulus(OFF, 1'b0);
        step(1);    checkOutput("off_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        applyStimulus(MOVEB, 1'b0);
        step(10);
        applyStimulus(NO_ST, 1'b0);
        step(20);   checkOutput("pause_keeps", 16'h0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(KEEP_GO, 1'b0);
        step(1);    checkOutput("resume_no_tick", 16'h0002, 1'b0, 1'b1, 1'b0);
        step(1);    checkOutput("resume_mid_tick", 16'h0002, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(KEEP_GO, 1'b1);
        step(32);   checkOutput("hold_frozen", 16'h0003, 1'b0, 1'b1, 1'b0);
        applyStimulus(KEEP_GO, 1'b0);
        step(1);    checkOutput("hold_release", 16'h0011, 1'b0, 1'b1, 1'b0);

        applyStimulus(OFF, 1'b0);
        step(1);
        applyStimulus(MOVEF, 1'b0);
        step(39996); checkOutput("near_max",   16'h9998, 1'b1, 1'b1, 1'b0);
        step(1);     checkOutput("at_max",     16'h9999, 1'b0, 1'b1, 1'b0);
        step(3);     checkOutput("wrap_tick",  16'h9999, 1'b1, 1'b1, 1'b1);
        step(1);     checkOutput("wrap_value", AFTER_WRAP, 1'b0, 1'b1, 1'b1);
        step(8);     checkOutput("ovf_sticky", AFTER_WRAP2, 1'b0, 1'b1, 1'b1);
        applyStimulus(NO_ST, 1'b0);
        step(1);     checkOutput("ovf_paused", AFTER_WRAP2, 1'b0, 1'b0, 1'b1);
        applyStimulus(OFF, 1'b0);
        step(1);     checkOutput("ovf_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

        applyStimulus(MOVEF, 1'b0);
        step(6);
        #1 rst = 1'b1;
        #1 checkOutput("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1);
        rst = 1'b0;

        for (int it = 0; it < 300; it++) begin
            logic [3:0] s;
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0)
                s = OFF;
            else if (r < 12)
                s = run_codes[$urandom_range(0, 3)];
            else if (r < 16)
                s = ($urandom_range(0, 1) == 0) ? NO_ST : START;
            else
                s = 4'($urandom_range(0, 15));
            applyStimulus(s, ($urandom_range(0, 3) == 0));
            step(int'($urandom_range(1, 12)));
            if ($urandom_range(0, 29) == 0) begin
                #1 rst = 1'b1;
                #1 checkOutput("async_reset_rand", 16'h0000, 1'b0, 1'b0, 1'b0);
                step(1);
                rst = 1'b0;
            end
        end

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
